// File: rtl/layer_pkg.sv
// layer_pkg: shared state encoding, derived widths and weight saturation helper
package layer_pkg;

    typedef enum logic [1:0] {IDLE, ERR, UPD, DONE} upd_state_t;

    function automatic int width_e(input int width_o);
        return width_o + 1;
    endfunction

    function automatic int width_p(input int width_o, input int width_i);
        return width_o + width_i + 1;
    endfunction

    // Clamp a signed value into the range of a w-bit signed weight
    function automatic logic signed [31:0] sat_w(input logic signed [31:0] sum, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        return sum > hi ? hi : (sum < lo ? lo : sum);
    endfunction

endpackage

// File: rtl/layer_update_sat_add.sv
// sat_add: signed adder whose result is clamped to a WY-bit signed range
module sat_add
    import layer_pkg::*;
#(
    parameter int WA = 9,
    parameter int WB = 12,
    parameter int WY = 9
) (
    input  logic signed [WA-1:0] a,
    input  logic signed [WB-1:0] b,
    output logic signed [WY-1:0] y
);
    localparam int WS = (WA > WB ? WA : WB) + 1;

    logic signed [WS-1:0] sum;

    assign sum = WS'(a) + WS'(b);
    assign y   = WY'(sat_w(32'(sum), WY));

endmodule

// File: rtl/layer_update.sv
// layer_update: weight store for the forward layer with a sequential delta-rule update pass
module layer_update
    import layer_pkg::*;
#(
    parameter int LENGHT_I = 2,
    parameter int LENGHT_O = 1,
    parameter int WIDTH_W  = 9,
    parameter int WIDTH_I  = 1,
    parameter int WIDTH_O  = 10,
    parameter int SHIFT_LR = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      load,
    input  logic [LENGHT_I*LENGHT_O-1:0][WIDTH_W-1:0] w_init,
    input  logic                                      start,
    input  logic [LENGHT_I-1:0][WIDTH_I-1:0]          in,
    input  logic [LENGHT_O-1:0][WIDTH_O-1:0]          out_act,
    input  logic [LENGHT_O-1:0][WIDTH_O-1:0]          target,
    output logic [LENGHT_I*LENGHT_O-1:0][WIDTH_W-1:0] w_o,
    output logic                                      busy,
    output logic                                      done
);
    localparam int N       = LENGHT_I * LENGHT_O;
    localparam int WIDTH_E = width_e(WIDTH_O);
    localparam int WIDTH_P = width_p(WIDTH_O, WIDTH_I);
    localparam int KW      = LENGHT_O > 1 ? $clog2(LENGHT_O) : 1;
    localparam int MW      = LENGHT_I > 1 ? $clog2(LENGHT_I) : 1;
    localparam int JW      = N > 1 ? $clog2(N) : 1;

    upd_state_t state, state_nx;

    logic [KW-1:0]                   k;
    logic [MW-1:0]                   m;
    logic [JW-1:0]                   j;
    logic                            last_m, last;
    logic [LENGHT_I-1:0][WIDTH_I-1:0] in_q;
    logic [LENGHT_O-1:0][WIDTH_O-1:0] out_q, tgt_q;
    logic [LENGHT_O-1:0][WIDTH_E-1:0] err;
    logic [N-1:0][WIDTH_W-1:0]        w;
    logic signed [WIDTH_P-1:0]       p, d;
    logic signed [WIDTH_W-1:0]       w_new;

    assign j      = JW'(k * LENGHT_I + m);
    assign last_m = m == MW'(LENGHT_I - 1);
    assign last   = last_m && k == KW'(LENGHT_O - 1);

    // err is signed, the input is an unsigned magnitude and is zero-extended
    assign p = $signed({{(WIDTH_P-WIDTH_E){err[k][WIDTH_E-1]}}, err[k]})
             * $signed({{(WIDTH_P-WIDTH_I){1'b0}}, in_q[m]});
    assign d = p >>> SHIFT_LR;

    sat_add #(.WA(WIDTH_W), .WB(WIDTH_P), .WY(WIDTH_W)) u_sat (
        .a(w[j]),
        .b(d),
        .y(w_new)
    );

    assign w_o  = w;
    assign busy = state == ERR || state == UPD;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !load && start ? ERR : IDLE;
            ERR:     state_nx = UPD;
            UPD:     state_nx = last ? DONE : UPD;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w     <= '0;
            k     <= '0;
            m     <= '0;
            in_q  <= '0;
            out_q <= '0;
            tgt_q <= '0;
            err   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        w <= w_init;
                    end else if (start) begin
                        in_q  <= in;
                        out_q <= out_act;
                        tgt_q <= target;
                    end
                end
                ERR: begin
                    for (int i = 0; i < LENGHT_O; i++)
                        err[i] <= {1'b0, tgt_q[i]} - {1'b0, out_q[i]};
                    k <= '0;
                    m <= '0;
                end
                UPD: begin
                    w[j] <= w_new;
                    m    <= last_m ? '0 : m + 1'b1;
                    k    <= last_m ? k + 1'b1 : k;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_update.sv
// tb_layer_update: directed vectors with a done-driven scoreboard for two layer_update configurations
module tb_layer_update;

    logic clk = 0;
    always #5 clk = ~clk;

    logic              rst_n, load, start, busy, done;
    logic [1:0][8:0]   w_init, w_o;
    logic [1:0][0:0]   in_v;
    logic [0:0][9:0]   out_act, target;

    logic              rst2_n, load2, start2, busy2, done2;
    logic [3:0][8:0]   w_init2, w_o2;
    logic [1:0][0:0]   in2;
    logic [1:0][9:0]   out2, tgt2;

    int n_cmp = 0;
    int n_fail = 0;

    logic [17:0] q1[$];
    logic [35:0] q2[$];

    layer_update dut (
        .clk(clk), .rst_n(rst_n), .load(load), .w_init(w_init), .start(start),
        .in(in_v), .out_act(out_act), .target(target),
        .w_o(w_o), .busy(busy), .done(done)
    );

    layer_update #(.LENGHT_O(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .load(load2), .w_init(w_init2), .start(start2),
        .in(in2), .out_act(out2), .target(tgt2),
        .w_o(w_o2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q1.size() == 0) chk("dut_unexpected_done", 1, 0);
            else chk("dut_pass_w", w_o, q1.pop_front());
        end
        if (done2) begin
            if (q2.size() == 0) chk("dut2_unexpected_done", 1, 0);
            else chk("dut2_pass_w", w_o2, q2.pop_front());
        end
    end

    task automatic ld1(input logic [17:0] v);
        @(negedge clk);
        w_init = v;
        load   = 1;
        @(negedge clk);
        load = 0;
        chk("load_w", w_o, v);
        chk("load_busy", busy, 0);
    endtask

    task automatic pass1(input logic [1:0] iv, input logic [9:0] o, input logic [9:0] t,
                         input logic [17:0] e, input bit disturb);
        @(negedge clk);
        in_v    = iv;
        out_act = o;
        target  = t;
        start   = 1;
        q1.push_back(e);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 0;
            if (disturb && i == 2) begin
                start   = 1;
                load    = 1;
                w_init  = '1;
                in_v    = '0;
                target  = '0;
                out_act = 10'd1000;
            end
            if (disturb && i == 3) begin
                start = 0;
                load  = 0;
            end
            chk($sformatf("busy_c%0d", i), busy, i <= 3);
            chk($sformatf("done_c%0d", i), done, i == 4);
        end
    endtask

    task automatic ld2(input logic [35:0] v);
        @(negedge clk);
        w_init2 = v;
        load2   = 1;
        @(negedge clk);
        load2 = 0;
        chk("load2_w", w_o2, v);
    endtask

    initial begin
        rst_n = 0; load = 0; start = 0; w_init = '0; in_v = '0; out_act = '0; target = '0;
        rst2_n = 0; load2 = 0; start2 = 0; w_init2 = '0; in2 = '0; out2 = '0; tgt2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_w", w_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst2_w", w_o2, 0);
        rst_n  = 1;
        rst2_n = 1;

        // basic update: err=400, in={1,1}, d=100
        ld1({9'(-5), 9'(10)});
        pass1(2'b11, 10'd100, 10'd500, {9'(95), 9'(110)}, 0);

        // saturation both ways
        ld1({9'(-200), 9'(250)});
        pass1(2'b11, 10'd100, 10'd500, {9'(-100), 9'(255)}, 0);
        ld1({9'(-200), 9'(250)});
        pass1(2'b11, 10'd500, 10'd100, {9'(-256), 9'(150)}, 0);

        // rounding toward -inf and zero input
        ld1({9'(7), 9'(0)});
        pass1(2'b01, 10'd3, 10'd0, {9'(7), 9'(-1)}, 0);

        // commands and input changes during the pass are ignored
        ld1({9'(-5), 9'(10)});
        pass1(2'b11, 10'd100, 10'd500, {9'(95), 9'(110)}, 1);

        // load and start together: load wins, no pass
        @(negedge clk);
        w_init = {9'(2), 9'(1)};
        load   = 1;
        start  = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                load  = 0;
                start = 0;
            end
            chk("ls_w", w_o, {9'(2), 9'(1)});
            chk("ls_busy", busy, 0);
        end

        // mid-pass reset on the two-neuron instance
        ld2({9'(4), 9'(3), 9'(-5), 9'(10)});
        @(negedge clk);
        in2   = 2'b11;
        out2  = {10'd2, 10'd100};
        tgt2  = {10'd10, 10'd500};
        start2 = 1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) start2 = 0;
        end
        chk("mid_w0_written", w_o2[0], 9'(110));
        rst2_n = 0;
        #1;
        chk("mid_rst_w", w_o2, 0);
        chk("mid_rst_busy", busy2, 0);
        repeat (2) @(negedge clk);
        rst2_n = 1;
        repeat (6) @(negedge clk);
        chk("mid_rst_idle_busy", busy2, 0);

        // full pass afterwards: k0 err=400 -> +100, k1 err=8 -> +2
        ld2({9'(4), 9'(3), 9'(-5), 9'(10)});
        @(negedge clk);
        start2 = 1;
        q2.push_back({9'(6), 9'(5), 9'(95), 9'(110)});
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) start2 = 0;
            chk($sformatf("busy2_c%0d", i), busy2, i <= 5);
            chk($sformatf("done2_c%0d", i), done2, i == 6);
        end

        repeat (3) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
